operand_issue_stage: RTL

OPERAND_ISSUE_STAGE -- requirements
Module: operand_issue_stage

---
 rtl/operand_issue_stage_if.sv | 50 +++++
 rtl/operand_issue_stage.sv | 75 +++++++
 2 files changed

// File: rtl/operand_issue_stage_if.sv
// operand_issue_stage_if: decode, bypass, control and execute-slot signals of the operand issue stage
interface operand_issue_stage_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_rd_we;
    logic        id_is_load;
    logic [15:0] id_ctrl;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_wd;
    logic        flush;
    logic        ex_hold;
    logic        ex_valid;
    logic        ex_rd_we;
    logic        ex_is_load;
    logic [31:0] ex_pc;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic        stall_id;
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
    modport master (
        output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rd_we, id_is_load, id_ctrl, rf_rd1, rf_rd2, mem_rd, mem_we, mem_wd,
               wb_rd, wb_we, wb_wd, flush, ex_hold,
        input  ex_valid, ex_rd_we, ex_is_load, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_ctrl, stall_id, bubble_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rd_we, id_is_load, id_ctrl, rf_rd1, rf_rd2, mem_rd, mem_we, mem_wd,
               wb_rd, wb_we, wb_wd, flush, ex_hold,
        output ex_valid, ex_rd_we, ex_is_load, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_ctrl, stall_id, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: bypassed operand select, load-use stall and execute-slot register with event counters
module operand_issue_stage (
    input logic                   clk,
    input logic                   rst,
    operand_issue_stage_if.slave  io
);
    logic        ex_valid_q, ex_rd_we_q, ex_is_load_q;
    logic [31:0] ex_pc_q, ex_op1_q, ex_op2_q, ex_imm_q;
    logic [4:0]  ex_rd_q;
    logic [15:0] ex_ctrl_q;
    logic [31:0] bubble_cnt_q, flush_cnt_q;
    logic [31:0] op1, op2;
    logic        load_use;
    // MEM is younger than WB, so its result shadows WB for the same register
    always_comb begin
        op1 = io.id_rs1 == 5'd0 ? 32'd0 :
              (io.mem_we && io.mem_rd == io.id_rs1) ? io.mem_wd :
              (io.wb_we && io.wb_rd == io.id_rs1) ? io.wb_wd : io.rf_rd1;
        op2 = io.id_rs2 == 5'd0 ? 32'd0 :
              (io.mem_we && io.mem_rd == io.id_rs2) ? io.mem_wd :
              (io.wb_we && io.wb_rd == io.id_rs2) ? io.wb_wd : io.rf_rd2;
        load_use = io.id_valid && ex_valid_q && ex_is_load_q && ex_rd_q != 5'd0 &&
                   ((io.id_use_rs1 && io.id_rs1 == ex_rd_q) ||
                    (io.id_use_rs2 && io.id_rs2 == ex_rd_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_pc_q      <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (io.flush) begin
            ex_valid_q   <= 1'b0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            flush_cnt_q  <= flush_cnt_q + 32'd1;
        end else if (!io.ex_hold) begin
            if (load_use) begin
                ex_valid_q   <= 1'b0;
                ex_rd_we_q   <= 1'b0;
                ex_is_load_q <= 1'b0;
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end else begin
                ex_valid_q   <= io.id_valid;
                ex_rd_we_q   <= io.id_rd_we && io.id_valid;
                ex_is_load_q <= io.id_is_load && io.id_valid;
                ex_pc_q      <= io.id_pc;
                ex_op1_q     <= op1;
                ex_op2_q     <= op2;
                ex_imm_q     <= io.id_imm;
                ex_rd_q      <= io.id_rd;
                ex_ctrl_q    <= io.id_ctrl;
            end
        end
    end
    assign io.stall_id   = (load_use || io.ex_hold) && !io.flush;
    assign io.ex_valid   = ex_valid_q;
    assign io.ex_rd_we   = ex_rd_we_q;
    assign io.ex_is_load = ex_is_load_q;
    assign io.ex_pc      = ex_pc_q;
    assign io.ex_op1     = ex_op1_q;
    assign io.ex_op2     = ex_op2_q;
    assign io.ex_imm     = ex_imm_q;
    assign io.ex_rd      = ex_rd_q;
    assign io.ex_ctrl    = ex_ctrl_q;
    assign io.bubble_cnt = bubble_cnt_q;
    assign io.flush_cnt  = flush_cnt_q;
endmodule
